// File: rtl/vga_fb_scanout_if.sv
// Framebuffer read port between the scanout block and a synchronous RAM.
// Handshake: none. The master presents fb_addr from a register. The slave returns
// fb_data exactly one clk later. There is no valid/ready pair, and the RAM is
// assumed to accept an address on every clk.
interface vga_fb_scanout_if #(
  parameter int ADDRESS_WIDTH = 19,
  parameter int DATA_WIDTH    = 8
);
  logic [ADDRESS_WIDTH-1:0] fb_addr;
  logic [DATA_WIDTH-1:0]    fb_data;

  modport master (output fb_addr, input fb_data);
  modport slave  (input fb_addr, output fb_data);
endinterface

// File: rtl/vga_fb_scanout.sv
// VGA framebuffer scanout: free-running raster counters, incremental framebuffer
// address generation, and a one-pixel-period output stage. The output stage
// expands RRRGGGBB bytes to 4:4:4 RGB, aligned with hsync/vsync.
// CLK_DIV must be >= 2 so that the RAM's 1-clk read latency fits inside a pixel.
module vga_fb_scanout #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int CLK_DIV       = 4,
  parameter int ADDRESS_WIDTH = 19,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  vga_fb_scanout_if.master    fb,
  output logic                hsync,
  output logic                vsync,
  output logic [3:0]          vga_r,
  output logic [3:0]          vga_g,
  output logic [3:0]          vga_b,
  output logic                video_de,
  output logic                frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

  logic [DW-1:0]         div_cnt;
  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic                  pix_en;
  logic                  active;
  logic                  h_wrap;
  logic                  frame_wrap;
  logic                  last_active;
  logic [DATA_WIDTH-1:0] pix_byte;
  logic [11:0]           rgb_next;

  // Decode the current raster position and expand the RAM byte to 4:4:4.
  always_comb begin
    pix_en      = (div_cnt == DIV_LAST);
    active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    h_wrap      = (h_cnt == H_LAST);
    frame_wrap  = h_wrap && (v_cnt == V_LAST);
    last_active = (h_cnt == H_ACT_LAST) && (v_cnt == V_ACT_LAST);
    pix_byte    = fb.fb_data;
    // Bit replication makes full-scale codes reach 4'hF and zero stay 4'h0.
    rgb_next    = {pix_byte[7:5], pix_byte[7],
                   pix_byte[4:2], pix_byte[4],
                   pix_byte[1:0], pix_byte[1:0]};
  end

  // Clock divider and free-running horizontal/vertical raster counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= pix_en ? '0 : div_cnt + DW'(1);
      if (pix_en) begin
        if (h_wrap) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
          h_cnt <= h_cnt + HW'(1);
        end
      end
    end
  end

  // Incremental address: advance past each visible pixel. On the final pixel it
  // stays at the last address so it never exceeds it, and it holds through
  // h-blank. It returns to 0 when leaving the last visible line, then sits at 0
  // through v-blank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb.fb_addr <= '0;
    end else if (pix_en) begin
      if (active && !last_active) begin
        fb.fb_addr <= fb.fb_addr + ADDR_ONE;
      end else if (h_wrap && (v_cnt == V_ACT_LAST)) begin
        fb.fb_addr <= '0;
      end
    end
  end

  // Output stage: register the pre-edge position and fb_data so that sync,
  // enable and colour all describe the same pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vga_r       <= 4'h0;
      vga_g       <= 4'h0;
      vga_b       <= 4'h0;
      video_de    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && frame_wrap;
      if (pix_en) begin
        hsync    <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vsync    <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        video_de <= active;
        {vga_r, vga_g, vga_b} <= active ? rgb_next : 12'h000;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout. It has a small-raster instance (8/2/2/2 x 4/1/1/1, CLK_DIV=4)
// with a RAM holding data=addr (except 8'hE3 at address 5). It also has a full
// 640x480 instance with CLK_DIV=2 that is checked for one line plus the
// first pixel of the next.
module tb_vga_fb_scanout;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_s = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs and RAM models ----------------
  vga_fb_scanout_if #(.ADDRESS_WIDTH(5),  .DATA_WIDTH(8)) fb_s ();
  vga_fb_scanout_if #(.ADDRESS_WIDTH(19), .DATA_WIDTH(8)) fb_b ();

  logic       hsync_s, vsync_s, de_s, fs_s;
  logic [3:0] r_s, g_s, b_s;
  logic       hsync_b, vsync_b, de_b, fs_b;
  logic [3:0] r_b, g_b, b_b;

  vga_fb_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(4), .ADDRESS_WIDTH(5), .DATA_WIDTH(8)
  ) dut_s (
    .clk(clk), .reset_n(rst_s), .fb(fb_s),
    .hsync(hsync_s), .vsync(vsync_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
    .video_de(de_s), .frame_start(fs_s)
  );

  vga_fb_scanout #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .CLK_DIV(2), .ADDRESS_WIDTH(19), .DATA_WIDTH(8)
  ) dut_b (
    .clk(clk), .reset_n(rst_b), .fb(fb_b),
    .hsync(hsync_b), .vsync(vsync_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .video_de(de_b), .frame_start(fs_b)
  );

  logic [7:0] mem_s [0:31];
  always @(posedge clk) fb_s.fb_data <= mem_s[fb_s.fb_addr];
  always @(posedge clk) fb_b.fb_data <= fb_b.fb_addr[7:0];

  // ---------------- scoreboard ----------------
  int tests  = 0;
  int failed = 0;
  logic [14:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] expand(input logic [7:0] d);
    return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
  endfunction

  // Expected {de, hsync, vsync, rgb} for output pixel p of the small raster.
  function automatic logic [14:0] small_exp(input int p);
    int q, h, v;
    logic de, hs, vs;
    logic [11:0] rgb;
    q   = p % 98;
    h   = q % 14;
    v   = q / 14;
    de  = (h < 8) && (v < 4);
    hs  = !((h >= 10) && (h < 12));
    vs  = (v != 5);
    rgb = de ? expand(mem_s[v * 8 + h]) : 12'h000;
    return {de, hs, vs, rgb};
  endfunction

  // Expected fb_addr while the small raster counters sit at position q.
  function automatic int small_addr(input int q_in);
    int q, h, v;
    q = q_in % 98;
    h = q % 14;
    v = q / 14;
    if (v >= 4) return 0;
    if (h < 8)  return v * 8 + h;
    if (v == 3) return 31;
    return (v + 1) * 8;
  endfunction

  // Expected fb_addr while the full raster counters sit at position q (first lines only).
  function automatic int big_addr(input int q);
    int h, v;
    h = q % 800;
    v = q / 800;
    if (h < 640) return v * 640 + h;
    return (v + 1) * 640;
  endfunction

  // ---------------- drivers ----------------
  // Step n pixel periods of the small raster; p0 is the first output pixel index.
  task automatic run_small(input int n, input int p0);
    logic [14:0] e;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(small_exp(p0 + k));
      for (int j = 0; j < 4; j++) begin
        @(posedge clk);
        #1;
        check("s_frame_start", 32'(fs_s),
              32'((j == 3) && (((p0 + k) % 98) == 97)));
      end
      e = exp_q.pop_front();
      check("s_pixel", 32'({de_s, hsync_s, vsync_s, r_s, g_s, b_s}), 32'(e));
      check("s_fb_addr", 32'(fb_s.fb_addr), 32'(small_addr(p0 + k + 1)));
    end
  endtask

  // Step n pixel periods of the full raster starting at output pixel 0.
  task automatic run_big(input int n);
    int h, v, a;
    logic de, hs;
    logic [11:0] rgb;
    for (int p = 0; p < n; p++) begin
      for (int j = 0; j < 2; j++) begin
        @(posedge clk);
        #1;
      end
      h   = p % 800;
      v   = p / 800;
      a   = v * 640 + h;
      de  = (h < 640);
      hs  = !((h >= 656) && (h < 752));
      rgb = de ? expand(a[7:0]) : 12'h000;
      check("b_pixel", 32'({de_b, hsync_b, vsync_b, r_b, g_b, b_b}), 32'({de, hs, 1'b1, rgb}));
      check("b_fb_addr", 32'(fb_b.fb_addr), 32'(big_addr(p + 1)));
      check("b_frame_start", 32'(fs_b), 32'(0));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 32; i++) mem_s[i] = 8'(i);
    mem_s[5] = 8'hE3;

    // Reset values, asserted asynchronously.
    #1;
    rst_s = 1'b0;
    rst_b = 1'b0;
    #1;
    check("rst_s_outputs", 32'({hsync_s, vsync_s, de_s, fs_s, r_s, g_s, b_s}), 32'h0000_C000);
    check("rst_s_fb_addr", 32'(fb_s.fb_addr), 32'(0));
    check("rst_b_outputs", 32'({hsync_b, vsync_b, de_b, fs_b, r_b, g_b, b_b}), 32'h0000_C000);
    check("rst_b_fb_addr", 32'(fb_b.fb_addr), 32'(0));
    repeat (3) @(posedge clk);

    // Two full frames of the small raster: line/frame timing, address trace,
    // colour expansion (including 8'hE3 at pixel (5,0)), frame_start pulses.
    @(negedge clk);
    rst_s = 1'b1;
    run_small(196, 0);

    // Walk to counters (3,2), go one clk into that pixel, then drop reset between edges.
    run_small(31, 0);
    @(posedge clk);
    #2;
    rst_s = 1'b0;
    #1;
    check("midreset_outputs", 32'({hsync_s, vsync_s, de_s, fs_s, r_s, g_s, b_s}), 32'h0000_C000);
    check("midreset_fb_addr", 32'(fb_s.fb_addr), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_s = 1'b1;
    run_small(20, 0);

    // Full 640x480 timing with CLK_DIV=2: one 800-pixel (1600-clk) line plus the
    // first pixel of line 1.
    @(negedge clk);
    rst_b = 1'b1;
    run_big(801);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
